// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared widths, FSM state encoding and hazard helpers for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned WAIT_W = 8;
   localparam int unsigned CNT_W  = 32;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_MD_WAIT  = 2'd2
   } hz_state_e;

   // True when the ID instruction reads a register that the EX-stage load has not produced yet.
   function automatic logic load_use_hit(
      input logic             ld,
      input logic [REG_W-1:0] rd,
      input logic [REG_W-1:0] rs1,
      input logic [REG_W-1:0] rs2,
      input logic             use1,
      input logic             use2
   );
      return ld && (rd != '0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory / mul-div stalls, jump redirect and load-use bubbles.
// Stage controls respond in the same cycle as the hazard, so they are decoded
// combinationally from the FSM state and the current pipeline inputs.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jmp_en_i,
   input  logic [ADDR_W-1:0] jmp_to_i,
   input  logic              ld_ex_i,
   input  logic [REG_W-1:0]  rd_ex_i,
   input  logic [REG_W-1:0]  rs1_id_i,
   input  logic [REG_W-1:0]  rs2_id_i,
   input  logic              rs1_use_i,
   input  logic              rs2_use_i,
   input  logic              mem_req_i,
   input  logic              mem_ready_i,
   input  logic              md_start_i,
   input  logic              md_done_i,
   output logic              jmp_en_o,
   output logic [ADDR_W-1:0] jmp_to_o,
   output logic              pc_hold_n,
   output logic              if_id_hold_n,
   output logic              id_ex_hold_n,
   output logic              ex_mem_hold_n,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              bus_err_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   // Value of the wait counter during the MEM_TIMEOUT-th cycle spent in MEM_WAIT.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_e          state_q;
   hz_state_e          state_d;
   logic [WAIT_W-1:0]  wait_cnt_q;
   logic [CNT_W-1:0]   stall_cnt_q;
   logic               stalled;
   logic               load_use;

   assign jmp_to_o    = jmp_to_i;
   assign stall_cnt_o = rst ? '0 : stall_cnt_q;
   assign load_use    = load_use_hit(ld_ex_i, rd_ex_i, rs1_id_i, rs2_id_i, rs1_use_i, rs2_use_i);

   // Next-state decode and stage-control outputs; reset forces a clean bubble-everything response.
   always_comb begin
      state_d       = state_q;
      stalled       = 1'b0;
      bus_err_o     = 1'b0;
      jmp_en_o      = 1'b0;
      pc_hold_n     = 1'b1;
      if_id_hold_n  = 1'b1;
      id_ex_hold_n  = 1'b1;
      ex_mem_hold_n = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_req_i && !mem_ready_i) begin
               state_d = ST_MEM_WAIT;
               stalled = 1'b1;
            end else if (md_start_i && !md_done_i) begin
               state_d = ST_MD_WAIT;
               stalled = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready_i) begin
               state_d = ST_RUN;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d   = ST_RUN;
               bus_err_o = 1'b1;
            end else begin
               stalled = 1'b1;
            end
         end
         ST_MD_WAIT: begin
            if (md_done_i) begin
               state_d = ST_RUN;
            end else begin
               stalled = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // A release cycle is an ordinary unstalled cycle, so a held jump or load-use is served here.
      if (stalled) begin
         pc_hold_n     = 1'b0;
         if_id_hold_n  = 1'b0;
         id_ex_hold_n  = 1'b0;
         ex_mem_hold_n = 1'b0;
      end else if (jmp_en_i) begin
         jmp_en_o    = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_hold_n    = 1'b0;
         if_id_hold_n = 1'b0;
         id_ex_flush  = 1'b1;
      end

      if (rst) begin
         state_d       = ST_RUN;
         bus_err_o     = 1'b0;
         jmp_en_o      = 1'b0;
         pc_hold_n     = 1'b1;
         if_id_hold_n  = 1'b1;
         id_ex_hold_n  = 1'b1;
         ex_mem_hold_n = 1'b1;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
      end
   end

   // State, memory-wait counter and saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= (state_q == ST_MEM_WAIT) ? wait_cnt_q + WAIT_W'(1) : '0;
         if (!pc_hold_n && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a behavioural stall/jump/load-use model.
module tb_pipe_hazard_ctrl;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        jmp_en_i;
   logic [31:0] jmp_to_i;
   logic        ld_ex_i;
   logic [4:0]  rd_ex_i;
   logic [4:0]  rs1_id_i;
   logic [4:0]  rs2_id_i;
   logic        rs1_use_i;
   logic        rs2_use_i;
   logic        mem_req_i;
   logic        mem_ready_i;
   logic        md_start_i;
   logic        md_done_i;
   logic        jmp_en_o;
   logic [31:0] jmp_to_o;
   logic        pc_hold_n;
   logic        if_id_hold_n;
   logic        id_ex_hold_n;
   logic        ex_mem_hold_n;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        bus_err_o;
   logic [31:0] stall_cnt_o;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .jmp_en_i     (jmp_en_i),
      .jmp_to_i     (jmp_to_i),
      .ld_ex_i      (ld_ex_i),
      .rd_ex_i      (rd_ex_i),
      .rs1_id_i     (rs1_id_i),
      .rs2_id_i     (rs2_id_i),
      .rs1_use_i    (rs1_use_i),
      .rs2_use_i    (rs2_use_i),
      .mem_req_i    (mem_req_i),
      .mem_ready_i  (mem_ready_i),
      .md_start_i   (md_start_i),
      .md_done_i    (md_done_i),
      .jmp_en_o     (jmp_en_o),
      .jmp_to_o     (jmp_to_o),
      .pc_hold_n    (pc_hold_n),
      .if_id_hold_n (if_id_hold_n),
      .id_ex_hold_n (id_ex_hold_n),
      .ex_mem_hold_n(ex_mem_hold_n),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .bus_err_o    (bus_err_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   typedef struct packed {
      logic        rst;
      logic        jmp_en;
      logic [31:0] jmp_to;
      logic        ld_ex;
      logic [4:0]  rd_ex;
      logic [4:0]  rs1_id;
      logic [4:0]  rs2_id;
      logic        rs1_use;
      logic        rs2_use;
      logic        mem_req;
      logic        mem_ready;
      logic        md_start;
      logic        md_done;
   } stim_t;

   stim_t s;
   int    total = 0;
   int    bad   = 0;

   // Reference model: which stall is pending, how many memory-wait cycles have elapsed, stall total.
   bit          m_mem  = 1'b0;
   bit          m_md   = 1'b0;
   int          m_wait = 0;
   logic [31:0] m_cnt  = '0;

   // Last observed outputs, for scenario-specific checks.
   logic [3:0]  obs_hold;
   logic [1:0]  obs_flush;
   logic        obs_jmp;
   logic        obs_err;
   logic [31:0] obs_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: apply s, compare every output with the model, then advance the model.
   task automatic tick();
      logic [3:0] e_hold;
      logic [1:0] e_flush;
      logic       e_jmp;
      logic       e_err;
      logic       stall;
      logic       hz;

      @(negedge clk);
      rst         = s.rst;
      jmp_en_i    = s.jmp_en;
      jmp_to_i    = s.jmp_to;
      ld_ex_i     = s.ld_ex;
      rd_ex_i     = s.rd_ex;
      rs1_id_i    = s.rs1_id;
      rs2_id_i    = s.rs2_id;
      rs1_use_i   = s.rs1_use;
      rs2_use_i   = s.rs2_use;
      mem_req_i   = s.mem_req;
      mem_ready_i = s.mem_ready;
      md_start_i  = s.md_start;
      md_done_i   = s.md_done;
      #1;

      stall = 1'b0;
      e_err = 1'b0;
      if (m_mem) begin
         if (!s.mem_ready) begin
            if (m_wait + 1 == TMO) e_err = 1'b1;
            else                   stall = 1'b1;
         end
      end else if (m_md) begin
         stall = !s.md_done;
      end else begin
         stall = (s.mem_req && !s.mem_ready) || (s.md_start && !s.md_done);
      end

      hz = s.ld_ex && (s.rd_ex != 5'd0) &&
           ((s.rs1_use && (s.rs1_id == s.rd_ex)) || (s.rs2_use && (s.rs2_id == s.rd_ex)));

      e_hold  = 4'hF;
      e_flush = 2'b00;
      e_jmp   = 1'b0;
      if (stall) begin
         e_hold = 4'h0;
      end else if (s.jmp_en) begin
         e_jmp   = 1'b1;
         e_flush = 2'b11;
      end else if (hz) begin
         e_hold  = 4'b0011;
         e_flush = 2'b01;
      end
      if (s.rst) begin
         e_hold  = 4'hF;
         e_flush = 2'b11;
         e_jmp   = 1'b0;
         e_err   = 1'b0;
      end

      obs_hold  = {pc_hold_n, if_id_hold_n, id_ex_hold_n, ex_mem_hold_n};
      obs_flush = {if_id_flush, id_ex_flush};
      obs_jmp   = jmp_en_o;
      obs_err   = bus_err_o;
      obs_cnt   = stall_cnt_o;

      check("holds",     32'(obs_hold),  32'(e_hold));
      check("flushes",   32'(obs_flush), 32'(e_flush));
      check("jmp_en",    32'(obs_jmp),   32'(e_jmp));
      check("jmp_to",    jmp_to_o,       s.jmp_to);
      check("bus_err",   32'(obs_err),   32'(e_err));
      check("stall_cnt", obs_cnt,        s.rst ? 32'd0 : m_cnt);

      @(posedge clk);
      if (s.rst) begin
         m_mem  = 1'b0;
         m_md   = 1'b0;
         m_wait = 0;
         m_cnt  = '0;
      end else begin
         if (!e_hold[3] && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
         if (m_mem) begin
            if (s.mem_ready || e_err) m_mem = 1'b0;
            else                      m_wait++;
         end else if (m_md) begin
            if (s.md_done) m_md = 1'b0;
         end else if (s.mem_req && !s.mem_ready) begin
            m_mem  = 1'b1;
            m_wait = 0;
         end else if (s.md_start && !s.md_done) begin
            m_md = 1'b1;
         end
      end
   endtask

   initial begin
      s = '0;

      // Reset, then one idle cycle
      s.rst = 1'b1;
      tick();
      check("rst_holds", 32'(obs_hold), 32'hF);
      tick();
      s.rst = 1'b0;
      tick();

      // Jump in RUN
      s.jmp_en = 1'b1;
      s.jmp_to = 32'h8000_0040;
      tick();
      check("jump_en",    32'(obs_jmp),   32'd1);
      check("jump_flush", 32'(obs_flush), 32'h3);
      check("jump_holds", 32'(obs_hold),  32'hF);
      s.jmp_en = 1'b0;
      tick();

      // Load-use via rs2, then x0 destination which must not stall
      s.ld_ex   = 1'b1;
      s.rd_ex   = 5'd5;
      s.rs2_id  = 5'd5;
      s.rs2_use = 1'b1;
      tick();
      check("lu_holds", 32'(obs_hold),  32'h3);
      check("lu_flush", 32'(obs_flush), 32'h1);
      s.ld_ex = 1'b0;
      tick();
      check("lu_after", 32'(obs_hold), 32'hF);
      s.ld_ex  = 1'b1;
      s.rd_ex  = 5'd0;
      s.rs2_id = 5'd0;
      tick();
      check("lu_x0", 32'(obs_hold), 32'hF);
      s.ld_ex   = 1'b0;
      s.rs2_use = 1'b0;

      // Memory stall of three cycles released by ready
      s.rst = 1'b1;
      tick();
      s.rst     = 1'b0;
      s.mem_req = 1'b1;
      repeat (3) begin
         tick();
         check("mem_hold", 32'(obs_hold), 32'h0);
      end
      s.mem_ready = 1'b1;
      tick();
      check("mem_release", 32'(obs_hold), 32'hF);
      s.mem_req   = 1'b0;
      s.mem_ready = 1'b0;
      tick();
      check("mem_cnt", obs_cnt, 32'd3);

      // Timeout: ready never comes
      s.rst = 1'b1;
      tick();
      s.rst     = 1'b0;
      s.mem_req = 1'b1;
      tick();
      check("tmo_entry_err", 32'(obs_err), 32'd0);
      for (int i = 1; i <= TMO; i++) begin
         tick();
         check("tmo_err",  32'(obs_err),  (i == TMO) ? 32'd1 : 32'd0);
         check("tmo_hold", 32'(obs_hold), (i == TMO) ? 32'hF : 32'h0);
      end
      s.mem_req = 1'b0;
      tick();
      check("tmo_after_err",  32'(obs_err),  32'd0);
      check("tmo_after_hold", 32'(obs_hold), 32'hF);

      // Jump held across a mul/div wait
      s.rst = 1'b1;
      tick();
      s.rst      = 1'b0;
      s.md_start = 1'b1;
      s.jmp_en   = 1'b1;
      s.jmp_to   = 32'h1234_5678;
      tick();
      check("md_jmp_entry", 32'(obs_jmp), 32'd0);
      s.md_start = 1'b0;
      repeat (4) begin
         tick();
         check("md_jmp_wait", 32'(obs_jmp), 32'd0);
      end
      s.md_done = 1'b1;
      tick();
      check("md_jmp_done", 32'(obs_jmp), 32'd1);
      s.md_done = 1'b0;
      s.jmp_en  = 1'b0;
      tick();

      // Reset in the middle of a memory wait
      s.mem_req = 1'b1;
      tick();
      tick();
      s.rst = 1'b1;
      tick();
      check("rst_mid_hold", 32'(obs_hold), 32'hF);
      s.rst     = 1'b0;
      s.mem_req = 1'b0;
      tick();
      check("rst_after_hold", 32'(obs_hold), 32'hF);
      check("rst_after_cnt",  obs_cnt,       32'd0);
      check("rst_after_err",  32'(obs_err),  32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         s.rst       = ($urandom_range(0, 99) == 0);
         s.jmp_en    = ($urandom_range(0, 3) == 0);
         s.jmp_to    = $urandom;
         s.ld_ex     = ($urandom_range(0, 1) == 0);
         s.rd_ex     = 5'($urandom_range(0, 3));
         s.rs1_id    = 5'($urandom_range(0, 3));
         s.rs2_id    = 5'($urandom_range(0, 3));
         s.rs1_use   = ($urandom_range(0, 1) == 0);
         s.rs2_use   = ($urandom_range(0, 1) == 0);
         s.mem_req   = ($urandom_range(0, 3) == 0);
         s.mem_ready = ($urandom_range(0, 1) == 0);
         s.md_start  = ($urandom_range(0, 4) == 0);
         s.md_done   = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
